inst_queue: RTL and testbench
=============================

# inst_queue

Instruction queue between the fetch stage and the decode stage. Buffers up to DEPTH fetched {PC, Inst} packets so a decode stall does not immediately back-pressure fetch. Discards all buffered packets on a branch, exception or ertn flush. Flags misaligned PCs so decode can raise ADEF.

## Interface

Parameters:
- DEPTH, 4: number of entries; must be a power of two and ≥ 2.
- WIDTH, 64: packet width; bits 63:32 are PC, bits 31:0 are Inst.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  one clock; reset is synchronous and active-high (clk, reset).
- flush  in  1  branch/exception/ertn flush; discards all entries.
- in_valid  in  1  fetch has a packet on in_data.
- in_ready  out  1  queue accepts a packet this cycle.
- in_data  in  WIDTH  fetch packet {PC, Inst}.
- out_valid  out  1  head packet is valid for decode.
- out_ready  in  1  decode accepts the head packet this cycle.
- out_data  out  WIDTH  head packet.
- out_adef  out  1  head PC[1:0] != 0; qualified by out_valid.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation

Event definitions:
- push = in_valid & in_ready.
- pop = out_valid & out_ready.

Storage and pointers:
- Storage is DEPTH×WIDTH registers.
- Write pointer wp and read pointer rp are each $clog2(DEPTH) bits wide.
- Both pointers wrap modulo DEPTH with natural overflow.

Update priority on each clock edge:
- reset: wp = rp = count = 0.
- Otherwise, flush: wp = rp = count = 0. A push or pop in the same cycle is dropped.
- Otherwise, the following apply together:
  - push: mem[wp] ← in_data, wp+1.
  - pop: rp+1.
  - count: +1 on push only, −1 on pop only, unchanged on both or neither.

Output rules:
- in_ready = !reset & (count != DEPTH). It does not look at out_ready, so there is no push-through when full.
- out_valid = (count != 0). There is no combinational bypass from in_data.
- out_data = mem[rp] when out_valid, otherwise 0.
- out_adef = out_valid & (out_data[33:32] != 2'b00).
- Storage contents are never reset; only pointers and count are.

## Timing

Reset values, in the cycle after reset is sampled high: out_valid 0, out_data 0, out_adef 0, count 0, in_ready 1. in_ready is also 0 while reset is high.

Latency and throughput:
- A packet pushed at edge N is visible on out_data from edge N (out_valid high after N) when it is the head.
- Minimum push-to-pop latency is 1 cycle.
- Throughput is 1 packet/cycle when neither end stalls.

Boundary conditions:
- Full (count = DEPTH) with out_ready = 1: the pop occurs and no push is accepted that cycle. in_ready rises the next cycle.
- Empty with in_valid = 1: the push occurs and out_valid = 1 the next cycle.
- Simultaneous push and pop, 0 < count < DEPTH: count is unchanged and both pointers advance.
- Wrap-around: wp and rp wrap from DEPTH−1 to 0 with no gap. Ordering is strictly FIFO.
- Flush while full, with in_valid = 1: the queue is empty next cycle and the packet is not stored.
- Flush together with reset: reset wins; the result is identical.
- Reset mid-operation: all entries are lost and the queue is empty next cycle.
- count never exceeds DEPTH and never underflows.

## Structure

Shared package / defines.sv:
- Packet field constants: BUS_PC_HI = 63, BUS_PC_LO = 32, BUS_INST_HI = 31, BUS_INST_LO = 0.
- Default IQ_DEPTH = 4.
- Existing `RestEn, `true and `false macros.

No sub-module: storage, pointers and count are inline in inst_queue.

## Test plan

- Reset, then 4 pushes of {0x1C000000+4k, 0x02800000+k}, k=0..3, with out_ready=0. Required: count=4, in_ready=0, out_data={0x1C000000, 0x02800000}.
- Full queue, out_ready=1 and in_valid=1 for one cycle. Required: exactly one pop and no push; count=3, in_ready=1 next cycle, head PC=0x1C000004.
- Streaming: 10 packets with in_valid=out_ready=1 every cycle. Required: count stays ≤1, output order matches input order, pointers wrap twice with no loss.
- Flush with count=3 and in_valid=1 at the same edge. Required: next cycle count=0, out_valid=0, out_data=0; the next push is the next output.
- Push PC=0x1C000002. Required: out_adef=1 while it is head; out_adef=0 for PC=0x1C000008.
- Assert reset mid-stream with count=2. Required: next cycle count=0, out_valid=0, in_ready=0 during reset, in_ready=1 after release.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: shared constants for the fetch-to-decode instruction queue.
//   Packet layout : {PC[63:32], Inst[31:0]}
//   IQ_DEPTH      : default number of queue entries
//   IQ_WIDTH      : default packet width
//   pc_misaligned : true when the low two PC bits are non-zero (ADEF source)
package inst_queue_pkg;

    localparam int unsigned BUS_PC_HI   = 63;
    localparam int unsigned BUS_PC_LO   = 32;
    localparam int unsigned BUS_INST_HI = 31;
    localparam int unsigned BUS_INST_LO = 0;

    localparam int unsigned IQ_DEPTH = 4;
    localparam int unsigned IQ_WIDTH = 64;

    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

// File: rtl/inst_queue.sv
// inst_queue: FIFO of {PC, Inst} packets between fetch and decode.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   flush                 discards every buffered packet (branch/exception/ertn)
//   in_valid/in_ready     fetch-side handshake, in_data carries {PC, Inst}
//   out_valid/out_ready   decode-side handshake, out_data is the head packet
//   out_adef              head PC is not word aligned (qualified by out_valid)
//   count                 number of occupied entries, 0..DEPTH
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH,
    parameter int unsigned WIDTH = IQ_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_adef,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wp_q, rp_q;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    // in_ready ignores out_ready: a full queue never accepts a push, even while popping.
    assign in_ready  = !reset && (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_data  = out_valid ? mem_q[rp_q] : '0;
    assign out_adef  = out_valid && pc_misaligned(out_data[BUS_PC_LO+1:BUS_PC_LO]);
    assign count     = count_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            // Pointers are exactly PW bits, so they wrap at DEPTH by natural overflow.
            if (push) wp_q <= wp_q + 1'b1;
            if (pop)  rp_q <= rp_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage is never reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wp_q] <= in_data;
    end

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 64;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_adef;
    logic [2:0]       count;

    int tests;
    int fails;

    // Reference model: a plain queue of packets, head at index 0.
    logic [63:0] mq[$];

    inst_queue #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_adef (out_adef),
        .count    (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [63:0] head;
        head = (mq.size() != 0) ? mq[0] : 64'h0;
        chk("count",     64'(count),     64'(mq.size()));
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("out_data",  out_data,       head);
        chk("out_adef",  64'(out_adef),  64'((mq.size() != 0) && (head[33:32] != 2'b00)));
        chk("in_ready",  64'(in_ready),  64'(!reset && (mq.size() != DEPTH)));
    endtask

    // Check current outputs against the model, clock once, advance the model.
    task automatic tick();
        bit push, pop;
        #1;
        check_model();
        push = in_valid && !reset && (mq.size() != DEPTH);
        pop  = (mq.size() != 0) && out_ready;
        @(posedge clk);
        if (reset || flush) begin
            mq.delete();
        end else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(in_data);
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [63:0] d, input bit r, input bit f, input bit rst);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        reset     = rst;
    endtask

    initial begin
        int popped;
        tests = 0;
        fails = 0;
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("in_ready_in_reset", 64'(in_ready), 64'h0);

        // Reset values
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_count",     64'(count),     64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data",  out_data,       64'h0);
        chk("rst_out_adef",  64'(out_adef),  64'h0);
        chk("rst_in_ready",  64'(in_ready),  64'h1);

        // Fill with four packets while decode stalls
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, {32'h1C000000 + 32'(4 * k), 32'h02800000 + 32'(k)}, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("full_count",    64'(count),    64'h4);
        chk("full_in_ready", 64'(in_ready), 64'h0);
        chk("full_head",     out_data,      {32'h1C000000, 32'h02800000});

        // Full with both sides active: one pop, no push
        drive(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("fullpop_count",    64'(count),        64'h3);
        chk("fullpop_in_ready", 64'(in_ready),     64'h1);
        chk("fullpop_head_pc",  64'(out_data[63:32]), 64'h1C000004);

        // Drain, then stream 10 packets
        while (mq.size() != 0) begin
            drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        popped = 0;
        for (int k = 0; k < 12; k++) begin
            drive(k < 10, {32'h1C001000 + 32'(4 * k), 32'h03000000 + 32'(k)}, 1'b1, 1'b0, 1'b0);
            if (out_valid && out_ready) popped++;
            tick();
            chk("stream_count_le1", 64'(count <= 3'd1), 64'h1);
        end
        chk("stream_popped", 64'(popped), 64'd10);

        // Flush with three entries and a pending push
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, {32'h1C002000 + 32'(4 * k), 32'h0}, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 64'h1C00_3000_1111_1111, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("flush_count",     64'(count),     64'h0);
        chk("flush_out_valid", 64'(out_valid), 64'h0);
        chk("flush_out_data",  out_data,       64'h0);
        drive(1'b1, 64'h1C00_4000_2222_2222, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("post_flush_head", out_data, 64'h1C00_4000_2222_2222);
        drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        tick();

        // Misaligned PC flags ADEF while head
        drive(1'b1, {32'h1C000002, 32'h02800000}, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, {32'h1C000008, 32'h02800001}, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("adef_misaligned", 64'(out_adef), 64'h1);
        drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("adef_aligned", 64'(out_adef), 64'h0);
        chk("adef_count",   64'(count),    64'h1);

        // Reset mid-stream with two entries (one already held, push one more)
        drive(1'b1, 64'h1C00_5000_3333_3333, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 64'h1C00_5004_4444_4444, 1'b1, 1'b1, 1'b1);
        #1;
        chk("reset_in_ready_low", 64'(in_ready), 64'h0);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("reset_count",     64'(count),     64'h0);
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        chk("reset_in_ready",  64'(in_ready),  64'h1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0,
                  {$urandom, $urandom},
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 49) == 0);
            tick();
        end
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
